// File: rtl/vx_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : vx_wb_arbiter_if
// Brief    : Result-source bundle and GPR writeback/release bundle for the
//            writeback arbiter.
// Revision : 1.0
// ============================================================================
interface vx_wb_arbiter_if #(
    parameter int NUM_UNITS   = 4,
    parameter int NUM_THREADS = 4,
    parameter int XLEN        = 32,
    parameter int NR_BITS     = 6,
    parameter int WIS_BITS    = 2,
    parameter int PC_BITS     = 30
);
    logic [NUM_UNITS-1:0]                  in_valid;
    logic [NUM_UNITS-1:0]                  in_ready;
    logic [NUM_UNITS*WIS_BITS-1:0]         in_wis;
    logic [NUM_UNITS*NUM_THREADS-1:0]      in_tmask;
    logic [NUM_UNITS*PC_BITS-1:0]          in_PC;
    logic [NUM_UNITS-1:0]                  in_wb;
    logic [NUM_UNITS*NR_BITS-1:0]          in_rd;
    logic [NUM_UNITS*NUM_THREADS*XLEN-1:0] in_data;
    logic [NUM_UNITS-1:0]                  in_sop;
    logic [NUM_UNITS-1:0]                  in_eop;

    logic                                  wb_valid;
    logic [WIS_BITS-1:0]                   wb_wis;
    logic [NUM_THREADS-1:0]                wb_tmask;
    logic [PC_BITS-1:0]                    wb_PC;
    logic [NR_BITS-1:0]                    wb_rd;
    logic [NUM_THREADS*XLEN-1:0]           wb_data;
    logic                                  wb_sop;
    logic                                  wb_eop;

    logic                                  rel_valid;
    logic [WIS_BITS-1:0]                   rel_wis;
    logic [NR_BITS-1:0]                    rel_rd;

    modport master (
        output in_valid, in_wis, in_tmask, in_PC, in_wb, in_rd, in_data, in_sop, in_eop,
        input  in_ready,
        input  wb_valid, wb_wis, wb_tmask, wb_PC, wb_rd, wb_data, wb_sop, wb_eop,
        input  rel_valid, rel_wis, rel_rd
    );

    modport slave (
        input  in_valid, in_wis, in_tmask, in_PC, in_wb, in_rd, in_data, in_sop, in_eop,
        output in_ready,
        output wb_valid, wb_wis, wb_tmask, wb_PC, wb_rd, wb_data, wb_sop, wb_eop,
        output rel_valid, rel_wis, rel_rd
    );
endinterface
`default_nettype wire

// File: rtl/vx_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vx_wb_arbiter
// Brief    : Packet-granular round-robin merge of execution-unit results onto
//            the single GPR writeback port, with scoreboard release at eop.
// Revision : 1.0
// ============================================================================
module vx_wb_arbiter #(
    parameter int NUM_UNITS     = 4,
    parameter int NUM_THREADS   = 4,
    parameter int XLEN          = 32,
    parameter int NR_BITS       = 6,
    parameter int WIS_BITS      = 2,
    parameter int PC_BITS       = 30,
    parameter int PERF_CTR_BITS = 44
) (
    input  wire                      clk,
    input  wire                      reset,
    vx_wb_arbiter_if.slave           bus,
    output logic [PERF_CTR_BITS-1:0] perf_stalls
);
    localparam int c_ptr_w  = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int c_data_w = NUM_THREADS * XLEN;

    typedef enum logic [0:0] {
        ST_OPEN   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_t;

    lock_state_t                r_state, w_state_nxt;
    logic [c_ptr_w-1:0]         r_rr_ptr, w_rr_ptr_nxt;
    logic [c_ptr_w-1:0]         r_lock_idx, w_lock_idx_nxt;
    logic [NUM_UNITS-1:0]       w_grant;
    logic [c_ptr_w-1:0]         w_gidx;
    logic                       w_accept;
    int                         w_idx;
    logic                       w_sop, w_eop, w_wb, w_write;
    logic [NR_BITS-1:0]         w_rd;
    logic                       w_stall;
    logic [PERF_CTR_BITS-1:0]   r_perf;
    logic                       r_wb_valid, r_rel_valid;
    logic [WIS_BITS-1:0]        r_wb_wis;
    logic [NUM_THREADS-1:0]     r_wb_tmask;
    logic [PC_BITS-1:0]         r_wb_pc;
    logic [NR_BITS-1:0]         r_wb_rd;
    logic [c_data_w-1:0]        r_wb_data;
    logic                       r_wb_sop, r_wb_eop;

    // Scan from the pointer with wrap; while locked only the owner can match.
    always_comb begin
        w_grant  = '0;
        w_gidx   = '0;
        w_accept = 1'b0;
        w_idx    = 0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            w_idx = int'(r_rr_ptr) + k;
            if (w_idx >= NUM_UNITS) w_idx = w_idx - NUM_UNITS;
            if (!w_accept && bus.in_valid[w_idx] &&
                (r_state == ST_OPEN || c_ptr_w'(w_idx) == r_lock_idx)) begin
                w_accept       = 1'b1;
                w_gidx         = c_ptr_w'(w_idx);
                w_grant[w_idx] = 1'b1;
            end
        end
    end

    assign bus.in_ready = w_grant;
    assign w_sop        = bus.in_sop[w_gidx];
    assign w_eop        = bus.in_eop[w_gidx];
    assign w_wb         = bus.in_wb[w_gidx];
    assign w_rd         = bus.in_rd[w_gidx*NR_BITS +: NR_BITS];
    assign w_write      = w_accept && w_wb && (w_rd != '0);
    assign w_stall      = |(bus.in_valid & ~w_grant);

    always_comb begin
        w_state_nxt    = r_state;
        w_lock_idx_nxt = r_lock_idx;
        w_rr_ptr_nxt   = r_rr_ptr;
        if (w_accept) begin
            if (w_eop) begin
                w_state_nxt  = ST_OPEN;
                w_rr_ptr_nxt = (w_gidx == c_ptr_w'(NUM_UNITS - 1)) ? '0 : w_gidx + 1'b1;
            end else if (w_sop) begin
                w_state_nxt    = ST_LOCKED;
                w_lock_idx_nxt = w_gidx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_OPEN;
            r_rr_ptr    <= '0;
            r_lock_idx  <= '0;
            r_perf      <= '0;
            r_wb_valid  <= 1'b0;
            r_rel_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_lock_idx  <= w_lock_idx_nxt;
            r_perf      <= r_perf + PERF_CTR_BITS'(w_stall);
            r_wb_valid  <= w_write;
            r_rel_valid <= w_write && w_eop;
        end
    end

    // Payload needs no reset: it is only meaningful alongside the strobes.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_wb_wis   <= bus.in_wis[w_gidx*WIS_BITS +: WIS_BITS];
            r_wb_tmask <= bus.in_tmask[w_gidx*NUM_THREADS +: NUM_THREADS];
            r_wb_pc    <= bus.in_PC[w_gidx*PC_BITS +: PC_BITS];
            r_wb_rd    <= w_rd;
            r_wb_data  <= bus.in_data[w_gidx*c_data_w +: c_data_w];
            r_wb_sop   <= w_sop;
            r_wb_eop   <= w_eop;
        end
    end

    assign bus.wb_valid  = r_wb_valid;
    assign bus.wb_wis    = r_wb_wis;
    assign bus.wb_tmask  = r_wb_tmask;
    assign bus.wb_PC     = r_wb_pc;
    assign bus.wb_rd     = r_wb_rd;
    assign bus.wb_data   = r_wb_data;
    assign bus.wb_sop    = r_wb_sop;
    assign bus.wb_eop    = r_wb_eop;
    assign bus.rel_valid = r_rel_valid;
    assign bus.rel_wis   = r_wb_wis;
    assign bus.rel_rd    = r_wb_rd;
    assign perf_stalls   = r_perf;

    a_sop_when_open: assert property (@(posedge clk) disable iff (reset)
        (w_accept && r_state == ST_OPEN) |-> w_sop);

endmodule
`default_nettype wire

// File: tb/tb_vx_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vx_wb_arbiter
// Brief    : Directed and randomized bench for vx_wb_arbiter against a
//            packet-level reference model.
// Revision : 1.0
// ============================================================================
module tb_vx_wb_arbiter;
    localparam int N   = 4;
    localparam int T   = 4;
    localparam int X   = 32;
    localparam int NR  = 6;
    localparam int W   = 2;
    localparam int PCB = 30;
    localparam int PFB = 44;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [PFB-1:0] perf_stalls;

    vx_wb_arbiter_if #(.NUM_UNITS(N), .NUM_THREADS(T), .XLEN(X), .NR_BITS(NR),
                       .WIS_BITS(W), .PC_BITS(PCB)) bus ();

    vx_wb_arbiter #(.NUM_UNITS(N), .NUM_THREADS(T), .XLEN(X), .NR_BITS(NR),
                    .WIS_BITS(W), .PC_BITS(PCB), .PERF_CTR_BITS(PFB)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .perf_stalls (perf_stalls)
    );

    always #5 clk = ~clk;

    // Source-side beat presented by each unit
    bit             sv[N], ssop[N], seop[N], swb[N];
    logic [W-1:0]   swis[N];
    logic [T-1:0]   stm[N];
    logic [PCB-1:0] spc[N];
    logic [NR-1:0]  srd[N];
    logic [T*X-1:0] sdat[N];

    // Reference model: packet owner (-1 = none) and next-preferred unit
    int     m_ptr = 0, m_owner = -1, last_g = -1;
    longint m_perf = 0;
    bit     e_wbv, e_relv, e_sop, e_eop;
    logic [W-1:0]   e_wis;
    logic [T-1:0]   e_tm;
    logic [PCB-1:0] e_pc;
    logic [NR-1:0]  e_rd;
    logic [T*X-1:0] e_dat;

    int checks = 0, errors = 0;
    int g_left[N];

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        for (int u = 0; u < N; u++) begin
            bus.in_valid[u]           = sv[u];
            bus.in_sop[u]             = ssop[u];
            bus.in_eop[u]             = seop[u];
            bus.in_wb[u]              = swb[u];
            bus.in_wis[u*W +: W]      = swis[u];
            bus.in_tmask[u*T +: T]    = stm[u];
            bus.in_PC[u*PCB +: PCB]   = spc[u];
            bus.in_rd[u*NR +: NR]     = srd[u];
            bus.in_data[u*T*X +: T*X] = sdat[u];
        end
    endtask

    task automatic clear();
        for (int u = 0; u < N; u++) sv[u] = 1'b0;
    endtask

    task automatic set_beat(input int u, input bit sop, input bit eop, input bit wb,
                            input logic [NR-1:0] rd, input logic [W-1:0] wis,
                            input logic [T-1:0] tm, input logic [T*X-1:0] dat);
        sv[u] = 1'b1; ssop[u] = sop; seop[u] = eop; swb[u] = wb;
        srd[u] = rd; swis[u] = wis; stm[u] = tm; sdat[u] = dat;
        spc[u] = PCB'($urandom);
    endtask

    // One clock: inputs settle, ready is checked, the edge is taken, outputs checked.
    task automatic step();
        int g;
        logic [N-1:0] exp_rdy;
        bit stall;
        drive();
        #1;
        g = -1;
        if (m_owner >= 0) begin
            if (sv[m_owner]) g = m_owner;
        end else begin
            for (int k = 0; k < N; k++) begin
                int u;
                u = (m_ptr + k) % N;
                if (g < 0 && sv[u]) g = u;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("in_ready", bus.in_ready, exp_rdy);
        stall = 1'b0;
        for (int k = 0; k < N; k++) if (sv[k] && k != g) stall = 1'b1;
        last_g = g;
        e_wbv = 1'b0; e_relv = 1'b0;
        if (reset) begin
            m_ptr = 0; m_owner = -1; m_perf = 0;
        end else begin
            if (stall) m_perf++;
            if (g >= 0) begin
                e_wbv  = swb[g] && (srd[g] != '0);
                e_relv = e_wbv && seop[g];
                e_wis = swis[g]; e_tm = stm[g]; e_pc = spc[g]; e_rd = srd[g];
                e_dat = sdat[g]; e_sop = ssop[g]; e_eop = seop[g];
                if (seop[g]) begin
                    m_owner = -1;
                    m_ptr   = (g + 1) % N;
                end else if (ssop[g]) begin
                    m_owner = g;
                end
            end
        end
        @(posedge clk);
        #1;
        check("wb_valid", bus.wb_valid, e_wbv);
        check("rel_valid", bus.rel_valid, e_relv);
        check("perf_stalls", perf_stalls, m_perf);
        if (e_wbv) begin
            check("wb_wis", bus.wb_wis, e_wis);
            check("wb_tmask", bus.wb_tmask, e_tm);
            check("wb_PC", bus.wb_PC, e_pc);
            check("wb_rd", bus.wb_rd, e_rd);
            check("wb_data", bus.wb_data, e_dat);
            check("wb_sop", bus.wb_sop, e_sop);
            check("wb_eop", bus.wb_eop, e_eop);
        end
        if (e_relv) begin
            check("rel_wis", bus.rel_wis, e_wis);
            check("rel_rd", bus.rel_rd, e_rd);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        clear();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    function automatic logic [T*X-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        for (int u = 0; u < N; u++) begin
            g_left[u] = 0;
            set_beat(u, 1'b1, 1'b1, 1'b0, '0, '0, '0, '0);
            sv[u] = 1'b0;
        end
        @(negedge clk);
        do_reset();

        // Two single-beat sources contend every cycle: strict alternation
        set_beat(0, 1, 1, 1, 6'd5, 2'd0, 4'hF, rnd_data());
        set_beat(2, 1, 1, 1, 6'd7, 2'd2, 4'hF, rnd_data());
        for (int i = 0; i < 6; i++) begin
            step();
            check("alt_grant", last_g, (i % 2) ? 2 : 0);
        end

        // Three-beat packet blocks a continuously valid neighbour
        do_reset();
        set_beat(3, 1, 1, 1, 6'd11, 2'd3, 4'hF, rnd_data());
        for (int b = 0; b < 3; b++) begin
            set_beat(1, b == 0, b == 2, 1, 6'd9, 2'd1, 4'hF, rnd_data());
            step();
            check("pkt_grant", last_g, 1);
        end
        sv[1] = 1'b0;
        step();
        check("after_pkt_grant", last_g, 3);

        // x0 destination is consumed without write or release, pointer still moves
        do_reset();
        set_beat(2, 1, 1, 1, 6'd0, 2'd2, 4'hF, rnd_data());
        step();
        check("x0_grant", last_g, 2);
        set_beat(3, 1, 1, 1, 6'd4, 2'd3, 4'hF, rnd_data());
        step();
        check("x0_ptr_grant", last_g, 3);

        // wb=0 beat is dropped
        clear();
        set_beat(0, 1, 1, 0, 6'd12, 2'd0, 4'hF, rnd_data());
        step();
        check("nowb_grant", last_g, 0);
        check("nowb_no_write", bus.wb_valid, 1'b0);

        // Reset in the middle of unit 2's packet
        do_reset();
        set_beat(1, 1, 1, 1, 6'd2, 2'd1, 4'hF, rnd_data());
        step();
        sv[1] = 1'b0;
        set_beat(2, 1, 0, 1, 6'd8, 2'd2, 4'hF, rnd_data());
        step();
        check("pre_rst_grant", last_g, 2);
        do_reset();
        set_beat(0, 1, 1, 1, 6'd6, 2'd0, 4'hF, rnd_data());
        set_beat(2, 1, 0, 1, 6'd8, 2'd2, 4'hF, rnd_data());
        step();
        check("post_rst_grant", last_g, 0);
        sv[0] = 1'b0;
        step();
        set_beat(2, 0, 1, 1, 6'd8, 2'd2, 4'hF, rnd_data());
        step();
        check("post_rst_eop_grant", last_g, 2);

        // Partial lane mask with distinct lane payloads
        clear();
        set_beat(0, 1, 1, 1, 6'd3, 2'd1, 4'b0101,
                 {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001});
        step();
        check("lane_tmask", bus.wb_tmask, 4'b0101);
        check("lane_data", bus.wb_data,
              {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001});
        check("lane_wis", bus.wb_wis, 2'd1);
        check("lane_rd", bus.wb_rd, 6'd3);

        // Randomized legal traffic: packets of 1..3 beats, bubbles, holds
        clear();
        step();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int u = 0; u < N; u++) begin
                if (!sv[u]) begin
                    if (g_left[u] == 0) begin
                        if ($urandom_range(0, 2) == 0) begin
                            g_left[u] = $urandom_range(1, 3);
                            set_beat(u, 1, g_left[u] == 1, $urandom_range(0, 7) != 0,
                                     ($urandom_range(0, 7) == 0) ? 6'd0 : NR'($urandom_range(1, 63)),
                                     W'($urandom), T'($urandom), rnd_data());
                        end
                    end else if ($urandom_range(0, 3) != 0) begin
                        set_beat(u, 0, g_left[u] == 1, swb[u], srd[u], swis[u],
                                 T'($urandom), rnd_data());
                    end
                end
            end
            step();
            if (last_g >= 0) begin
                sv[last_g] = 1'b0;
                g_left[last_g]--;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/vx_wb_arbiter.md
Name: vx_wb_arbiter

Overview:
- Merges result streams from NUM_UNITS execution units into the single GPR writeback port consumed by the operand collector's banked register file.
- Arbitration is round-robin per packet; multi-beat packets (sop..eop) are never interleaved.
- Emits a registered per-beat GPR write plus a one-shot scoreboard release at each packet's eop.
- The writeback port has no backpressure, so every accepted beat appears on the output exactly one cycle later.

Parameters:
- NUM_UNITS, 4, number of result sources (>=1).
- NUM_THREADS, 4, lanes per beat.
- XLEN, 32, bits per lane.
- NR_BITS, 6, register index width.
- WIS_BITS, 2, warp-in-slice index width (>=1).
- PC_BITS, 30, PC width.
- PERF_CTR_BITS, 44, stall counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  NUM_UNITS  per-unit beat valid.
- in_ready  out  NUM_UNITS  per-unit accept (combinational from grant).
- in_wis  in  NUM_UNITS*WIS_BITS  warp slot.
- in_tmask  in  NUM_UNITS*NUM_THREADS  lane write mask.
- in_PC  in  NUM_UNITS*PC_BITS  debug PC.
- in_wb  in  NUM_UNITS  1 = write GPR.
- in_rd  in  NUM_UNITS*NR_BITS  destination register.
- in_data  in  NUM_UNITS*NUM_THREADS*XLEN  lane results.
- in_sop  in  NUM_UNITS  first beat of packet.
- in_eop  in  NUM_UNITS  last beat of packet.
- wb_valid  out  1  GPR write strobe.
- wb_wis, wb_tmask, wb_PC, wb_rd, wb_data, wb_sop, wb_eop  out  (matching widths)  registered write fields.
- rel_valid  out  1  scoreboard release pulse.
- rel_wis  out  WIS_BITS  released warp slot.
- rel_rd  out  NR_BITS  released register.
- perf_stalls  out  PERF_CTR_BITS  stall cycles.

Behaviour:
- Reset state:
  - wb_valid=0, rel_valid=0.
  - rr_ptr=0, locked=0, lock_idx=0, perf_stalls=0.
  - Data outputs are don't-care.
- Eligibility:
  - When locked=1, only unit lock_idx is eligible.
  - Otherwise all units are eligible.
- Grant:
  - The first valid eligible unit scanning from rr_ptr upward, with wrap modulo NUM_UNITS.
  - At most one grant per cycle.
  - in_ready = one-hot grant; no dependence on downstream state.
  - Accept = in_valid[g] && in_ready[g].
- Lock:
  - On accept with sop=1 and eop=0: locked<=1, lock_idx<=g.
  - On accept with eop=1: locked<=0.
  - sop=eop=1 is a single-beat packet and never sets the lock.
  - Accept with sop=0 while unlocked is a protocol error: simulation assertion; the beat is still forwarded.
- Round-robin pointer:
  - Updates only on accept with eop=1: rr_ptr <= (g+1) mod NUM_UNITS.
  - Non-eop beats leave rr_ptr unchanged.
- Output stage (1-cycle latency):
  - On accept, the fields register on the next edge.
  - wb_valid <= in_wb[g] && (in_rd[g] != 0); x0 writes are suppressed.
  - wb_tmask is passed unchanged; all-zero tmask is legal and still strobes.
  - Beats with wb=0 are consumed and dropped, but still drive lock and pointer updates.
  - With no accept, wb_valid <= 0.
- Release:
  - rel_valid <= accept && in_eop[g] && in_wb[g] && (in_rd[g] != 0).
  - rel_wis and rel_rd are registered together with the wb fields, so release appears in the same cycle as the eop write.
- Performance counter: perf_stalls increments each cycle in which in_valid has any set bit that was not accepted (saturation not required).
- Hold rule: an input must hold its fields stable while valid and not ready; no re-check is done.
- Reset mid-packet: the lock clears immediately. The source is responsible for restarting with sop.
- NUM_UNITS=1: grant = in_valid[0], rr_ptr is constant 0, and lock logic remains functional.

Test Plan:
- Units 0 and 2 both send single-beat packets every cycle (rd=5 and rd=7, wb=1) -> grants alternate 0,2,0,2; each wb_valid appears 1 cycle after the accept; rel_valid accompanies every beat; perf_stalls +1 per cycle.
- Unit 1 sends a 3-beat packet (sop, mid, eop; rd=9) while unit 3 is continuously valid -> unit 3 is blocked for 3 cycles; wb_sop/wb_eop sequence is 1/0, 0/0, 0/1; one rel_valid with rd=9 on the last beat; unit 3 is granted next.
- A unit sends rd=0 with wb=1 (sop=eop=1) -> in_ready=1, wb_valid stays 0, rel_valid stays 0, rr_ptr advances.
- A unit sends wb=0 with tmask=4'hF -> beat consumed, no write, no release.
- Reset asserted mid-packet of unit 2 (after sop) -> next cycle wb_valid=0, locked=0, rr_ptr=0; unit 0 is granted ahead of unit 2.
- tmask=4'b0101, data lanes A,B,C,D on rd=3, wis=1 -> wb_tmask=4'b0101, wb_data is passed through intact, wb_wis=1, wb_rd=3.
